// File: rtl/instr_enc_if.sv
// Field-bundle handshake and program-memory write bus for the MSP430 instruction encoder.
interface instr_enc_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [3:0]  op;
    logic [3:0]  src_reg;
    logic [3:0]  dst_reg;
    logic [1:0]  As;
    logic        Ad;
    logic        BW;
    logic [15:0] src_ext;
    logic [15:0] dst_ext;
    logic [9:0]  jmp_off;
    logic        addr_load;
    logic [15:0] base_addr;
    logic        mem_ready;
    logic [15:0] MAB_out;
    logic [15:0] MDB_in;
    logic        MW;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  instr_len;

    modport master (
        output in_valid, fmt, op, src_reg, dst_reg, As, Ad, BW, src_ext, dst_ext,
               jmp_off, addr_load, base_addr, mem_ready,
        input  in_ready, MAB_out, MDB_in, MW, busy, done, err, instr_len
    );

    modport slave (
        input  in_valid, fmt, op, src_reg, dst_reg, As, Ad, BW, src_ext, dst_ext,
               jmp_off, addr_load, base_addr, mem_ready,
        output in_ready, MAB_out, MDB_in, MW, busy, done, err, instr_len
    );
endinterface

// File: rtl/instr_enc.sv
// MSP430 instruction encoder: turns decoded fields into the instruction word plus optional
// source/destination extension words and writes them to program memory at an incrementing address.
module instr_enc #(
    parameter logic [15:0] START_ADDR = 16'hC000,
    parameter logic [15:0] ADDR_STEP  = 16'd2
) (
    input logic        clk,
    input logic        rst,
    instr_enc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, W_INSTR, W_SRC, W_DST} state_t;

    state_t      state, state_nxt;
    logic [15:0] addr;
    logic [15:0] instr_word, src_word, dst_word;
    logic        src_need, dst_need;
    logic        done_r, err_r, last;
    logic [1:0]  len_r;
    logic        bad;

    function automatic logic bundle_bad(input logic [1:0] fmt, input logic [3:0] op);
        return (fmt == 2'd0) || (fmt == 2'd1 && op < 4'd4) || (fmt == 2'd2 && op[2:0] == 3'd7);
    endfunction

    function automatic logic [15:0] encode(input logic [1:0] fmt, input logic [3:0] op,
                                           input logic [3:0] sreg, input logic [3:0] dreg,
                                           input logic [1:0] as_m, input logic ad_m,
                                           input logic bw, input logic [9:0] off);
        case (fmt)
            2'd1:    return {op, sreg, ad_m, bw, as_m, dreg};
            2'd2:    return (op[2:0] == 3'd6) ? 16'h1300 : {6'b000100, op[2:0], bw, as_m, dreg};
            2'd3:    return {3'b001, op[2:0], off};
            default: return 16'h0000;
        endcase
    endfunction

    // R3 never needs an extension (constant generator); R2 only for the indexed/absolute form.
    function automatic logic src_ext_needed(input logic [1:0] fmt, input logic [3:0] sreg,
                                            input logic [3:0] dreg, input logic [1:0] as_m);
        logic [3:0] r;
        r = (fmt == 2'd1) ? sreg : dreg;
        if (fmt != 2'd1 && fmt != 2'd2) return 1'b0;
        return (as_m == 2'b01 && r != 4'd3) || (as_m == 2'b11 && r == 4'd0);
    endfunction

    assign bad           = bundle_bad(bus.fmt, bus.op);
    assign bus.busy      = (state != IDLE);
    assign bus.in_ready  = (state == IDLE);
    assign bus.MAB_out   = addr;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.instr_len = len_r;

    always_comb begin
        state_nxt  = state;
        bus.MW     = 1'b0;
        bus.MDB_in = 16'h0000;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid && !bad) state_nxt = W_INSTR;
            end
            W_INSTR: begin
                bus.MW     = 1'b1;
                bus.MDB_in = instr_word;
                if (bus.mem_ready) begin
                    if (src_need)      state_nxt = W_SRC;
                    else if (dst_need) state_nxt = W_DST;
                    else begin
                        state_nxt = IDLE;
                        last      = 1'b1;
                    end
                end
            end
            W_SRC: begin
                bus.MW     = 1'b1;
                bus.MDB_in = src_word;
                if (bus.mem_ready) begin
                    if (dst_need) state_nxt = W_DST;
                    else begin
                        state_nxt = IDLE;
                        last      = 1'b1;
                    end
                end
            end
            W_DST: begin
                bus.MW     = 1'b1;
                bus.MDB_in = dst_word;
                if (bus.mem_ready) begin
                    state_nxt = IDLE;
                    last      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr   <= START_ADDR;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            len_r  <= 2'd0;
        end else begin
            state  <= state_nxt;
            done_r <= last;
            err_r  <= 1'b0;
            if (state == IDLE) begin
                // A same-cycle load lands first, so an accepted bundle starts at base_addr.
                if (bus.addr_load) addr <= bus.base_addr & 16'hFFFE;
                if (bus.in_valid)  err_r <= bad;
            end else if (bus.mem_ready) begin
                addr <= addr + ADDR_STEP;
            end
            if (last) len_r <= 2'd1 + {1'b0, src_need} + {1'b0, dst_need};
        end
    end

    // Accepted bundle is captured once so later input changes cannot disturb the write burst.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid && !bad) begin
            instr_word <= encode(bus.fmt, bus.op, bus.src_reg, bus.dst_reg, bus.As, bus.Ad,
                                 bus.BW, bus.jmp_off);
            src_word   <= bus.src_ext;
            dst_word   <= bus.dst_ext;
            src_need   <= src_ext_needed(bus.fmt, bus.src_reg, bus.dst_reg, bus.As);
            dst_need   <= (bus.fmt == 2'd1) && bus.Ad;
        end
    end
endmodule

// File: tb/tb_instr_enc.sv
// Scoreboard bench for instr_enc: directed cases from the encoding rules plus randomized bundles.
module tb_instr_enc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_enc_if bus();
    instr_enc #(.START_ADDR(16'hC000), .ADDR_STEP(16'd2)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [1:0]  fmt;
        logic [3:0]  op;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [1:0]  as_m;
        logic        ad;
        logic        bw;
        logic [15:0] sx;
        logic [15:0] dx;
        logic [9:0]  off;
    } bundle_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    int checks = 0;
    int failures = 0;
    wr_t wq[$];
    int lq[$];
    int eq[$];
    logic [15:0] hist_d[$];
    logic [15:0] hist_a[$];
    logic [15:0] model_addr;
    wr_t mon_w;
    int mon_l;
    int lat;
    logic [15:0] s_mab, s_mdb;
    bundle_t b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string detail);
        checks++;
        failures++;
        $display("FAIL %s %s", name, detail);
    endtask

    // Reference model: field arithmetic straight from the MSP430 instruction formats.
    function automatic bit model_bad(input bundle_t x);
        return x.fmt == 0 || (x.fmt == 1 && x.op < 4) || (x.fmt == 2 && (x.op & 4'h7) == 7);
    endfunction

    function automatic logic [15:0] model_word(input bundle_t x);
        case (x.fmt)
            2'd1: return 16'(x.op) * 16'd4096 + 16'(x.src) * 16'd256 + 16'(x.ad) * 16'd128
                       + 16'(x.bw) * 16'd64 + 16'(x.as_m) * 16'd16 + 16'(x.dst);
            2'd2: begin
                if ((x.op & 4'h7) == 6) return 16'h1300;
                return 16'h1000 + 16'(x.op & 4'h7) * 16'd128 + 16'(x.bw) * 16'd64
                       + 16'(x.as_m) * 16'd16 + 16'(x.dst);
            end
            2'd3: return 16'h2000 + 16'(x.op & 4'h7) * 16'd1024 + 16'(x.off);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit model_src(input bundle_t x);
        int r;
        if (x.fmt != 1 && x.fmt != 2) return 0;
        r = (x.fmt == 1) ? int'(x.src) : int'(x.dst);
        return (x.as_m == 1 && r != 3) || (x.as_m == 3 && r == 0);
    endfunction

    function automatic bit model_dst(input bundle_t x);
        return x.fmt == 1 && x.ad == 1'b1;
    endfunction

    function automatic bundle_t mk(input int fmt, input int op, input int src, input int dst,
                                   input int as_m, input int ad, input int bw,
                                   input int sx, input int dx, input int off);
        bundle_t x;
        x.fmt = 2'(fmt); x.op = 4'(op); x.src = 4'(src); x.dst = 4'(dst);
        x.as_m = 2'(as_m); x.ad = 1'(ad); x.bw = 1'(bw);
        x.sx = 16'(sx); x.dx = 16'(dx); x.off = 10'(off);
        return x;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t x;
        x = bundle_t'({$urandom, $urandom, $urandom});
        if (x.fmt == 2 && x.op[2:0] == 3'd6) begin
            x.as_m = 2'd0;
            x.dst  = 4'd0;
        end
        return x;
    endfunction

    task automatic drive(input bundle_t x);
        bus.fmt = x.fmt; bus.op = x.op; bus.src_reg = x.src; bus.dst_reg = x.dst;
        bus.As = x.as_m; bus.Ad = x.ad; bus.BW = x.bw;
        bus.src_ext = x.sx; bus.dst_ext = x.dx; bus.jmp_off = x.off;
    endtask

    task automatic expect_bundle(input bundle_t x);
        int len;
        if (model_bad(x)) begin
            eq.push_back(1);
        end else begin
            len = 1;
            wq.push_back({model_addr, model_word(x)});
            model_addr = model_addr + 16'd2;
            if (model_src(x)) begin
                wq.push_back({model_addr, x.sx});
                model_addr = model_addr + 16'd2;
                len++;
            end
            if (model_dst(x)) begin
                wq.push_back({model_addr, x.dx});
                model_addr = model_addr + 16'd2;
                len++;
            end
            lq.push_back(len);
        end
    endtask

    // Issue one bundle (optionally with a same-cycle address load) and wait for its outcome.
    task automatic issue(input bundle_t x, input bit ld, input logic [15:0] base, input bit rnd,
                         output int latency);
        int n;
        bit got;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) fail("ready_timeout", "actual=busy required=ready");
        drive(x);
        bus.in_valid = 1'b1;
        bus.addr_load = ld;
        bus.base_addr = base;
        if (ld) model_addr = base & 16'hFFFE;
        expect_bundle(x);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.addr_load = 1'b0;
        drive(rand_bundle());
        latency = 0;
        got = 0;
        if (!model_bad(x)) begin
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                latency++;
                if (bus.done) begin
                    got = 1;
                    break;
                end
                @(posedge clk); #1;
                if (rnd) bus.mem_ready = ($urandom_range(0, 3) != 0);
            end
            if (!got) fail("done_timeout", "actual=no_done required=done");
            @(posedge clk); #1;
            bus.mem_ready = 1'b1;
        end else begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        chk("addr_after", bus.MAB_out, model_addr);
    endtask

    // Monitor: every accepted write, done and err pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.MW && bus.mem_ready) begin
                hist_a.push_back(bus.MAB_out);
                hist_d.push_back(bus.MDB_in);
                if (wq.size() == 0) begin
                    fail("unexpected_write", $sformatf("actual=%0h@%0h required=none",
                                                       bus.MDB_in, bus.MAB_out));
                end else begin
                    mon_w = wq.pop_front();
                    chk("write_addr", bus.MAB_out, mon_w.a);
                    chk("write_data", bus.MDB_in, mon_w.d);
                end
            end
            if (bus.done) begin
                if (lq.size() == 0) begin
                    fail("unexpected_done", "actual=1 required=0");
                end else begin
                    mon_l = lq.pop_front();
                    chk("instr_len", bus.instr_len, mon_l);
                    chk("done_busy", bus.busy, 0);
                end
            end
            if (bus.err) begin
                if (eq.size() == 0) fail("unexpected_err", "actual=1 required=0");
                else void'(eq.pop_front());
                chk("err_mw", bus.MW, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 0; bus.addr_load = 0; bus.base_addr = 0; bus.mem_ready = 1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        model_addr = 16'hC000;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mw", bus.MW, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_len", bus.instr_len, 0);
        chk("rst_mdb", bus.MDB_in, 0);
        chk("rst_mab", bus.MAB_out, 16'hC000);
        @(posedge clk); #1;

        // MOV R5,R6
        hist_d.delete(); hist_a.delete();
        issue(mk(1, 4, 5, 6, 0, 0, 0, 0, 0, 0), 0, 0, 0, lat);
        chk("mov_rr_word", hist_d[0], 16'h4506);
        chk("mov_rr_addr", hist_a[0], 16'hC000);
        chk("mov_rr_lat", lat, 2);
        chk("mov_rr_len", bus.instr_len, 1);
        chk("mov_rr_next", bus.MAB_out, 16'hC002);

        // MOV #1234h,&0200h from a fresh address base
        bus.addr_load = 1; bus.base_addr = 16'hC000;
        @(posedge clk); #1;
        bus.addr_load = 0;
        model_addr = 16'hC000;
        hist_d.delete(); hist_a.delete();
        issue(mk(1, 4, 0, 2, 3, 1, 0, 16'h1234, 16'h0200, 0), 0, 0, 0, lat);
        chk("mov_imm_w0", hist_d[0], 16'h40B2);
        chk("mov_imm_w1", hist_d[1], 16'h1234);
        chk("mov_imm_w2", hist_d[2], 16'h0200);
        chk("mov_imm_a2", hist_a[2], 16'hC004);
        chk("mov_imm_lat", lat, 4);
        chk("mov_imm_len", bus.instr_len, 3);

        hist_d.delete();
        issue(mk(1, 5, 3, 7, 1, 0, 0, 16'hDEAD, 0, 0), 0, 0, 0, lat);
        chk("add_cg_word", hist_d[0], 16'h5317);
        chk("add_cg_len", bus.instr_len, 1);
        hist_d.delete();
        issue(mk(2, 4, 0, 10, 0, 0, 0, 0, 0, 0), 0, 0, 0, lat);
        chk("push_word", hist_d[0], 16'h120A);
        hist_d.delete();
        issue(mk(2, 6, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, lat);
        chk("reti_word", hist_d[0], 16'h1300);
        hist_d.delete();
        issue(mk(3, 7, 0, 0, 0, 0, 0, 0, 0, 10'h3FF), 0, 0, 0, lat);
        chk("jmp_word", hist_d[0], 16'h3FFF);
        chk("jmp_lat", lat, 2);

        // Address load to an odd address, then a two-word instruction across the wrap
        bus.addr_load = 1; bus.base_addr = 16'hFFFF;
        @(posedge clk); #1;
        bus.addr_load = 0;
        model_addr = 16'hFFFE;
        chk("load_mab", bus.MAB_out, 16'hFFFE);
        hist_a.delete();
        issue(mk(1, 4, 5, 6, 0, 1, 0, 0, 16'h0123, 0), 0, 0, 0, lat);
        chk("wrap_a0", hist_a[0], 16'hFFFE);
        chk("wrap_a1", hist_a[1], 16'h0000);

        // Memory stall while in W_SRC; a new bundle offered meanwhile must be ignored
        b = mk(1, 4, 0, 4, 3, 0, 0, 16'hABCD, 0, 0);
        drive(b);
        bus.in_valid = 1; bus.mem_ready = 1;
        expect_bundle(b);
        @(posedge clk); #1;
        bus.in_valid = 0;
        @(posedge clk); #1;
        bus.mem_ready = 0;
        drive(mk(1, 8, 1, 1, 0, 0, 0, 0, 0, 0));
        bus.in_valid = 1;
        @(negedge clk);
        chk("stall_mw", bus.MW, 1);
        s_mab = bus.MAB_out;
        s_mdb = bus.MDB_in;
        chk("stall_mdb", s_mdb, 16'hABCD);
        repeat (3) begin
            @(negedge clk);
            chk("stall_mw_hold", bus.MW, 1);
            chk("stall_mab_hold", bus.MAB_out, s_mab);
            chk("stall_mdb_hold", bus.MDB_in, s_mdb);
        end
        @(posedge clk); #1;
        bus.in_valid = 0;
        bus.mem_ready = 1;
        begin
            bit got;
            got = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bus.done) begin
                    got = 1;
                    break;
                end
            end
            if (!got) fail("stall_done_timeout", "actual=no_done required=done");
        end
        @(posedge clk); #1;
        chk("stall_addr", bus.MAB_out, model_addr);

        // Rejected bundles
        issue(mk(0, 4, 1, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, lat);
        issue(mk(1, 2, 1, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, lat);

        // Reset during W_DST aborts without done; the first two words were already written
        b = mk(1, 4, 0, 2, 3, 1, 0, 16'h0001, 16'h0002, 0);
        drive(b);
        bus.in_valid = 1; bus.mem_ready = 1;
        expect_bundle(b);
        void'(wq.pop_back());
        void'(lq.pop_back());
        @(posedge clk); #1;
        bus.in_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_dst", bus.MDB_in, 16'h0002);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_addr = 16'hC000;
        repeat (2) begin
            @(negedge clk);
            chk("abort_done", bus.done, 0);
            chk("abort_busy", bus.busy, 0);
            chk("abort_mab", bus.MAB_out, 16'hC000);
        end
        @(posedge clk); #1;

        for (int k = 0; k < 80; k++) begin
            b = rand_bundle();
            issue(b, $urandom_range(0, 7) == 0, 16'($urandom), 1, lat);
        end

        repeat (3) @(posedge clk);
        chk("pending_writes", wq.size(), 0);
        chk("pending_done", lq.size(), 0);
        chk("pending_err", eq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_enc.md
Name: instr_enc

Overview:
- Encodes decoded MSP430 instruction fields into the native word stream: the instruction word, then an optional source extension word, then an optional destination extension word.
- Writes each word to program memory at an auto-incrementing byte address.
- Works as the inverse of the instruction decoder. Used for boot-time program loading and to generate ROM images for the core under test.

Parameters:
- START_ADDR, 16'hC000, write address after reset.
- ADDR_STEP, 2, byte increment per word written.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- fmt  input  2  1=FMT_I, 2=FMT_II, 3=FMT_J, 0=invalid.
- op  input  4  FMT_I opcode [15:12]; FMT_II op[2:0] into [9:7]; FMT_J condition op[2:0] into [12:10].
- src_reg  input  4  source register (FMT_I).
- dst_reg  input  4  destination register (FMT_I); single register (FMT_II).
- As  input  2  source addressing mode.
- Ad  input  1  destination addressing mode (FMT_I only).
- BW  input  1  byte/word bit.
- src_ext  input  16  source extension word.
- dst_ext  input  16  destination extension word.
- jmp_off  input  10  signed word offset (FMT_J).
- addr_load  input  1  load write address from base_addr.
- base_addr  input  16  new write address; bit 0 forced to 0.
- mem_ready  input  1  memory accepts the current write.
- MAB_out  output  16  write address.
- MDB_in  output  16  write data.
- MW  output  1  memory write strobe.
- busy  output  1  not IDLE.
- done  output  1  one-cycle pulse: bundle fully written.
- err  output  1  one-cycle pulse: bundle rejected.
- instr_len  output  2  word count of the last encoded instruction (1-3).

Behaviour:
- Reset (synchronous, has priority over everything):
  - state=IDLE, addr=START_ADDR.
  - MW, done, err, busy = 0; instr_len=0; MDB_in=0.
  - in_ready=1 the cycle after reset is released.
  - An asserted rst mid-sequence aborts it. Words already written stay in memory; no done pulse.
- States: IDLE, W_INSTR, W_SRC, W_DST.
- IDLE:
  - in_ready=1.
  - addr_load sets addr=base_addr&16'hFFFE. It is honoured only in IDLE and ignored elsewhere.
  - If addr_load and in_valid fire in the same cycle, the load applies first. The bundle then begins at base_addr.
  - On in_valid&&in_ready, all fields are latched. Input changes after acceptance have no effect.
  - Invalid bundle: fmt==0, FMT_I with op<4, or FMT_II with op[2:0]==7.
    - err=1 for one cycle; state stays IDLE; no writes; addr unchanged.
  - Valid bundle: next state W_INSTR. The first MW is asserted in the cycle after acceptance.
- Encoding:
  - FMT_I = {op, src_reg, Ad, BW, As, dst_reg}.
  - FMT_II = {6'b000100, op[2:0], BW, As, dst_reg}. For op==6 (RETI) the word is forced to 16'h1300.
  - FMT_J = {3'b001, op[2:0], jmp_off}.
- Source extension needed (FMT_I src_reg / FMT_II dst_reg):
  - As==01 and reg != R3 (indexed, symbolic, absolute).
  - As==11 and reg==R0 (immediate).
  - Constant generator cases (R3 any As; R2 with As=10/11) need no extension.
- Destination extension needed: FMT_I and Ad==1. FMT_J never has extensions.
- W_INSTR, W_SRC, W_DST:
  - MW=1, MAB_out=addr, MDB_in=word for that state.
  - A word is accepted on the edge where MW&&mem_ready. On acceptance addr += ADDR_STEP, wrapping 16'hFFFE to 16'h0000.
  - Next state after acceptance:
    - From W_INSTR: W_SRC if a source extension is needed, else W_DST if a destination extension is needed, else IDLE.
    - From W_SRC: W_DST if needed, else IDLE.
    - From W_DST: IDLE.
  - While mem_ready=0, all outputs hold stable.
- On the final acceptance:
  - done=1 in the following cycle, coincident with the return to IDLE.
  - instr_len updates to 1+src_ext_needed+dst_ext_needed.
- busy=1 in every state except IDLE; in_ready = ~busy.
- MW=0 in IDLE.
- Minimum latency: acceptance to done is (instr_len + 1) cycles when mem_ready is held at 1.

Test Plan:
- Reset, then MOV R5,R6 (fmt=1 op=4 src=5 dst=6 As=0 Ad=0 BW=0), mem_ready=1:
  - one write, 16'h4506 @ C000; done one cycle later; instr_len=1; next addr C002.
- MOV #1234h,&0200h (src=0 As=3 dst=2 Ad=1 src_ext=1234 dst_ext=0200):
  - writes 40B2@C000, 1234@C002, 0200@C004; instr_len=3.
- Constant generator and FMT_II:
  - ADD via R3 (op=5 src=3 As=1 dst=7): single word 5317, no extension.
  - PUSH R10 (fmt=2 op=4 dst=10): 120A.
  - RETI (fmt=2 op=6): 1300.
- JMP (fmt=3 op=7 jmp_off=3FF) -> 3FFF. Then addr_load base_addr=FFFF followed by a 2-word instruction:
  - writes at FFFE then 0000 (wrap, bit 0 cleared).
- mem_ready held 0 for 3 cycles during W_SRC:
  - MW, MAB_out, MDB_in stable; in_valid ignored while busy; sequence completes after release.
- fmt=0 and fmt=1/op=2 bundles -> err pulse, no MW, addr unchanged.
- rst asserted during W_DST -> IDLE, addr=C000, no done.
